rr_hold_scheduler: RTL
======================

# rr_hold_scheduler

Round-robin scheduler that shares one single-owner resource (bus, memory port, accelerator) among `width` requesters. It holds each grant until the owner signals completion, drops its request, or (optionally) exceeds a hold limit. It then rotates priority to the requester after the last owner. The block is registered and built around a one-hot grant, and feeds the resource-side mux select and the requesters' grant lines.

## Interface
- `width`, 8, number of requesters (≥2)
- `HOLD_MAX`, 16, maximum grant cycles per ownership when timeout is compiled in (≥1)
- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-high reset
- `request` input `width`: per-requester level request
- `done` input 1: current owner finished; sampled only while `grant_valid`=1
- `grant` output `width`: one-hot registered grant, 0 when idle
- `grant_valid` output 1: `|grant`
- `grant_idx` output `$clog2(width)`: index of current owner, holds last value when idle
- `timeout` output 1: one-cycle pulse on forced revocation

## Operation
- The FSM has two states, IDLE and OWN.
- **Priority pointer `ptr`**:
  - Reset value 0.
  - On every release, `ptr` ← (owner idx + 1) mod `width`.
- **IDLE**:
  - `grant`=0.
  - If `request`≠0, the winner is the first set bit scanning `ptr`, `ptr`+1, … with wrap.
  - Next edge: `grant` ← onehot(winner), `grant_idx` ← winner, hold counter ← 1, state → OWN.
  - If `request`=0, stay in IDLE.
- **OWN**: release conditions, evaluated each cycle in this priority order:
  1. `done`=1
  2. `request[grant_idx]`=0
  3. Timeout (macro only): counter == `HOLD_MAX`
- **On release**:
  - Next edge: `grant` ← 0, state → IDLE, `ptr` updated.
  - `timeout` ← 1 only when condition 3 is the sole cause.
- **No release**: counter increments, saturating at `HOLD_MAX`.
- **Dead cycle**: every handoff has exactly one cycle with `grant`=0. No back-to-back grants, including re-grant to the same requester.
- Requests arriving or changing during OWN do not affect the current owner.
- **Counter**: width `$clog2(HOLD_MAX+1)`, unsigned, never wraps.
- **Reset**: applies at any time, including mid-ownership. Next edge: `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, `ptr`=0, counter=0, state IDLE.

## Timing
- Request-to-grant latency is 1 cycle from IDLE. `request` sampled at edge N gives `grant` valid after edge N.
- Grant-to-release latency is 1 cycle. `done` sampled at edge M gives `grant`=0 after edge M.
- Minimum ownership is 1 cycle. `done` may be high in the first grant cycle.
- Steady-state throughput under full load: one ownership per (hold length + 1) cycles.
- `timeout` is high for exactly the one cycle following revocation, coincident with the dead cycle.
- All outputs come directly from flops. There is no combinational input-to-output path.

## Configuration
- **`RR_HOLD_TIMEOUT_EN` defined**:
  - Hold counter and condition 3 are active.
  - A grant lasts at most `HOLD_MAX` cycles.
  - `timeout` pulses on forced revocation.
- **Not defined**:
  - Counter logic is removed.
  - A grant is held indefinitely until `done` or request drop.
  - `timeout` is tied to 0.
  - All other behaviour is identical.

## Test plan
Settings for all scenarios: `width`=4, `HOLD_MAX`=4, macro defined unless stated.

- **Reset**: hold `rst`=1 for 3 cycles with `request`=4'b1111 → `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0 throughout. After `rst` falls, `grant`=4'b0001 one cycle later.
- **Rotation**: `request`=4'b1111 constant, `done` pulsed in the 2nd cycle of each grant → `grant` sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 2 cycles, separated by exactly 1 zero cycle.
- **Wrap and skip**: after a release from idx 2, `request`=4'b0011 → next grant 4'b0001 (scan 3, 0), then 4'b0010.
- **Timeout**:
  - `request`=4'b0100, `done`=0 → `grant`=4'b0100 for exactly 4 cycles, then 0 with `timeout`=1 for 1 cycle, then 4'b0100 again.
  - Macro undefined → `grant` held for all 20 observed cycles and `timeout` never asserts.
- **Release ordering**:
  - `done`=1 in the 4th grant cycle → release with `timeout`=0.
  - Granted request drops in the 2nd cycle → `grant`=0 next cycle, `timeout`=0.
- **Reset mid-ownership**: `rst` pulsed in the 2nd cycle of a grant to idx 3 → `grant`=0 next cycle and `ptr`=0. With `request`=4'b1001, the next grant is 4'b0001.

Source files
------------

// File: rtl/rr_hold_scheduler.sv
// rr_hold_scheduler
//   Round-robin scheduler for one single-owner resource shared by `width`
//   requesters. A grant is held until the owner asserts `done`, drops its
//   request, or (with RR_HOLD_TIMEOUT_EN defined) has held it for HOLD_MAX
//   cycles. Priority then rotates to the requester after the last owner.
//   Every handoff includes one idle cycle with grant = 0.
//
// Optional feature macro: RR_HOLD_TIMEOUT_EN
//   defined     : hold counter active, forced revocation after HOLD_MAX cycles
//   not defined : no counter, grant held indefinitely, timeout tied low
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   request     in   [width]  per-requester level request
//   done        in   current owner finished (only looked at while owning)
//   grant       out  [width]  registered one-hot grant, 0 when idle
//   grant_valid out  registered |grant
//   grant_idx   out  [clog2(width)] current owner index, holds when idle
//   timeout     out  one-cycle pulse during the dead cycle of a forced release
module rr_hold_scheduler #(
  parameter int unsigned width    = 8,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [width-1:0]         request,
  input  logic                     done,
  output logic [width-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(width)-1:0] grant_idx,
  output logic                     timeout
);

  localparam int unsigned IDX_W = $clog2(width);

  if (width < 2 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("rr_hold_scheduler: needs width >= 2 and HOLD_MAX >= 1");
  end

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W-1:0] next_ptr;
  logic             rel_drop;
  logic             rel_to;
  logic             release_now;

  // Rotating scan starting at ptr; the first requester hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < width; i++) begin
      if (!found && request[(32'(ptr) + i) % width]) begin
        winner = IDX_W'((32'(ptr) + i) % width);
        found  = 1'b1;
      end
    end
  end

  // width need not be a power of two, so wrap explicitly.
  assign next_ptr = (grant_idx == IDX_W'(width - 1)) ? '0 : grant_idx + 1'b1;

  assign rel_drop    = !request[grant_idx];
  assign release_now = done || rel_drop || rel_to;

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign rel_to  = (hold_cnt == CNT_W'(HOLD_MAX));
  assign timeout = timeout_q;
`else
  assign rel_to  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
`ifdef RR_HOLD_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef RR_HOLD_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= width'(1) << winner;
            grant_valid <= 1'b1;
            grant_idx   <= winner;
            state       <= OWN;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_cnt    <= CNT_W'(1);
`endif
          end
        end
        OWN: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= next_ptr;
            state       <= IDLE;
`ifdef RR_HOLD_TIMEOUT_EN
            // Flag only a revocation that neither done nor a drop explains.
            timeout_q   <= !done && !rel_drop;
`endif
          end else begin
`ifdef RR_HOLD_TIMEOUT_EN
            if (!rel_to) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
